// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared defaults, FSM encoding and sign-extension helper for the FIR coefficient feeder
package fir_pkg;

  localparam int DEF_TAP_SIZE    = 6;
  localparam int DEF_NBR_OF_TAPS = 21;
  localparam int DEF_X_N_SIZE    = 8;
  localparam int DEF_INIT_WAIT   = 4;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_STREAM,
    ST_DRAIN,
    ST_LOAD,
    ST_GAP
  } state_t;

  // Replicates bit [width-1] of value into all higher bit positions.
  function automatic logic [31:0] sign_extend(input logic [31:0] value, input int width);
    logic [31:0] upper;
    upper = 32'hFFFF_FFFF << width;
    return value[width-1] ? (value | upper) : (value & ~upper);
  endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// rtl/fir_coeff_bank.sv - coefficient register file, identity image after reset, blockable write port
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int TAP_SIZE    = DEF_TAP_SIZE,
  parameter int NBR_OF_TAPS = DEF_NBR_OF_TAPS,
  parameter int ADDR_W      = $clog2(NBR_OF_TAPS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic                wr_block,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [TAP_SIZE-1:0] wr_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [TAP_SIZE-1:0] rd_data
);

  logic [TAP_SIZE-1:0] bank [NBR_OF_TAPS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NBR_OF_TAPS; i++) begin
        bank[i] <= (i == 0) ? TAP_SIZE'(1) : '0;
      end
    end else if (wr_en && !wr_block && (int'(wr_addr) < NBR_OF_TAPS)) begin
      bank[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (int'(rd_addr) < NBR_OF_TAPS) ? bank[rd_addr] : '0;

endmodule

// File: rtl/fir_coeff_feeder.sv
// rtl/fir_coeff_feeder.sv - sequences samples and coefficient loads into the adaptive FIR
// FIR_COEFF_FEEDER_BOOTLOAD_EN: shift the identity bank into the FIR before the first STREAM cycle
module fir_coeff_feeder
  import fir_pkg::*;
#(
  parameter int TAP_SIZE    = DEF_TAP_SIZE,
  parameter int NBR_OF_TAPS = DEF_NBR_OF_TAPS,
  parameter int X_N_SIZE    = DEF_X_N_SIZE,
  parameter int INIT_WAIT   = DEF_INIT_WAIT,
  parameter int ADDR_W      = $clog2(NBR_OF_TAPS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [X_N_SIZE-1:0] s_in_data,
  input  logic                s_in_valid,
  output logic                s_in_ready,
  input  logic                cfg_wr,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [TAP_SIZE-1:0] cfg_data,
  input  logic                cfg_commit,
  output logic                cfg_busy,
  output logic [X_N_SIZE-1:0] x_n,
  output logic                s_axis_fir_tvalid,
  output logic                s_set_coeffs
);

  localparam int BOOT_W = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(INIT_WAIT - 1);
  localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(NBR_OF_TAPS - 1);

  state_t              state;
  logic [BOOT_W-1:0]   boot_cnt;
  logic [ADDR_W-1:0]   load_idx;
  logic                commit_pend;
  logic [ADDR_W-1:0]   rd_addr;
  logic [TAP_SIZE-1:0] rd_data;
  logic [X_N_SIZE-1:0] coeff_ext;

  fir_coeff_bank #(
    .TAP_SIZE    (TAP_SIZE),
    .NBR_OF_TAPS (NBR_OF_TAPS),
    .ADDR_W      (ADDR_W)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (cfg_wr),
    .wr_block (state == ST_LOAD),
    .wr_addr  (cfg_addr),
    .wr_data  (cfg_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  // Address of the coefficient that goes on x_n at the next edge: the top entry
  // when entering LOAD, then walking down so bank[0] is shifted in last.
  assign rd_addr   = (state == ST_LOAD) ? ADDR_W'(NBR_OF_TAPS - 2) - load_idx
                                        : ADDR_W'(NBR_OF_TAPS - 1);
  assign coeff_ext = X_N_SIZE'(sign_extend(32'(rd_data), TAP_SIZE));

  assign s_in_ready = (state == ST_STREAM);
`ifdef FIR_COEFF_FEEDER_BOOTLOAD_EN
  assign cfg_busy = commit_pend | (state != ST_STREAM);
`else
  assign cfg_busy = commit_pend | ((state != ST_STREAM) && (state != ST_BOOT));
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= ST_BOOT;
      boot_cnt          <= '0;
      load_idx          <= '0;
      commit_pend       <= 1'b0;
      x_n               <= '0;
      s_axis_fir_tvalid <= 1'b0;
      s_set_coeffs      <= 1'b0;
    end else begin
      commit_pend       <= commit_pend | cfg_commit;
      s_axis_fir_tvalid <= 1'b0;
      s_set_coeffs      <= 1'b0;
      case (state)
        ST_BOOT: begin
          if (boot_cnt == BOOT_LAST) begin
`ifdef FIR_COEFF_FEEDER_BOOTLOAD_EN
            state <= ST_DRAIN;
`else
            state <= ST_STREAM;
`endif
          end else begin
            boot_cnt <= boot_cnt + 1'b1;
          end
        end
        ST_STREAM: begin
          if (s_in_valid) begin
            x_n               <= s_in_data;
            s_axis_fir_tvalid <= 1'b1;
          end
          if (commit_pend || cfg_commit) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // A commit arriving on this very edge still schedules another reload.
          commit_pend  <= cfg_commit;
          state        <= ST_LOAD;
          load_idx     <= '0;
          x_n          <= coeff_ext;
          s_set_coeffs <= 1'b1;
        end
        ST_LOAD: begin
          if (load_idx == LOAD_LAST) begin
            state <= ST_GAP;
            x_n   <= '0;
          end else begin
            load_idx     <= load_idx + 1'b1;
            x_n          <= coeff_ext;
            s_set_coeffs <= 1'b1;
          end
        end
        ST_GAP: begin
          state <= ST_STREAM;
        end
        default: begin
          state <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_feeder.sv
// tb/tb_fir_coeff_feeder.sv - randomized self-checking bench for fir_coeff_feeder against a cycle-list reference model
module tb_fir_coeff_feeder;

  localparam int N         = 21;
  localparam int INIT_WAIT = 4;
  localparam int ADDR_W    = 5;
`ifdef FIR_COEFF_FEEDER_BOOTLOAD_EN
  localparam bit BOOTLOAD = 1'b1;
`else
  localparam bit BOOTLOAD = 1'b0;
`endif
  localparam int BOOT_CYC = INIT_WAIT + (BOOTLOAD ? N + 2 : 0);

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        s_in_data;
  logic              s_in_valid;
  logic              s_in_ready;
  logic              cfg_wr;
  logic [ADDR_W-1:0] cfg_addr;
  logic [5:0]        cfg_data;
  logic              cfg_commit;
  logic              cfg_busy;
  logic [7:0]        x_n;
  logic              s_axis_fir_tvalid;
  logic              s_set_coeffs;

  fir_coeff_feeder dut (
    .clk               (clk),
    .reset             (reset),
    .s_in_data         (s_in_data),
    .s_in_valid        (s_in_valid),
    .s_in_ready        (s_in_ready),
    .cfg_wr            (cfg_wr),
    .cfg_addr          (cfg_addr),
    .cfg_data          (cfg_data),
    .cfg_commit        (cfg_commit),
    .cfg_busy          (cfg_busy),
    .x_n               (x_n),
    .s_axis_fir_tvalid (s_axis_fir_tvalid),
    .s_set_coeffs      (s_set_coeffs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ready;
    logic       busy;
    logic       set;
    logic       valid;
    logic [7:0] x;
  } cyc_t;

  cyc_t       exp_q[$];
  int         model_bank[N];
  logic [7:0] model_x;
  int         tests_run = 0;
  int         tests_failed = 0;

  function automatic void push_cyc(input logic r, input logic b, input logic s,
                                   input logic v, input logic [7:0] x);
    cyc_t c;
    c.ready = r; c.busy = b; c.set = s; c.valid = v; c.x = x;
    exp_q.push_back(c);
  endfunction

  // One coefficient load as seen on the pins: drain, N shifted coefficients
  // (highest index first, sign-extended), then a quiet gap.
  function automatic void push_load(input logic first_valid, input logic [7:0] first_x);
    int val;
    push_cyc(1'b0, 1'b1, 1'b0, first_valid, first_x);
    for (int j = 0; j < N; j++) begin
      val = model_bank[N-1-j];
      push_cyc(1'b0, 1'b1, 1'b1, 1'b0, val[7:0]);
    end
    push_cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
  endfunction

  function automatic void bank_identity();
    for (int i = 0; i < N; i++) model_bank[i] = (i == 0) ? 1 : 0;
  endfunction

  task automatic idle_inputs();
    s_in_valid = 1'b0;
    cfg_wr     = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    cyc_t e;
    reset = 1'b0;
    idle_inputs();
    cfg_addr   = '0;
    cfg_data   = '0;
    s_in_valid = 1'b1;
    s_in_data  = 8'h33;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({s_in_ready, s_set_coeffs, s_axis_fir_tvalid, x_n, cfg_busy} !== {11'b0, BOOTLOAD}) begin
      tests_failed++;
      $display("FAIL reset_state: got rdy=%b set=%b vld=%b x=%h busy=%b, want rdy=0 set=0 vld=0 x=00 busy=%b",
               s_in_ready, s_set_coeffs, s_axis_fir_tvalid, x_n, cfg_busy, BOOTLOAD);
    end
    bank_identity();
    exp_q.delete();
    for (int i = 0; i < INIT_WAIT - 1; i++) push_cyc(1'b0, BOOTLOAD, 1'b0, 1'b0, 8'h00);
    if (BOOTLOAD) push_load(1'b0, 8'h00);
    push_cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    push_cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h33);
    reset = 1'b1;
    for (int s = 0; s < exp_q.size(); s++) begin
      @(negedge clk);
      e = exp_q[s];
      tests_run++;
      if ({s_in_ready, cfg_busy, s_set_coeffs, s_axis_fir_tvalid, x_n} !== {e.ready, e.busy, e.set, e.valid, e.x}) begin
        tests_failed++;
        $display("FAIL boot step %0d: got rdy=%b busy=%b set=%b vld=%b x=%h, want rdy=%b busy=%b set=%b vld=%b x=%h",
                 s, s_in_ready, cfg_busy, s_set_coeffs, s_axis_fir_tvalid, x_n,
                 e.ready, e.busy, e.set, e.valid, e.x);
      end
    end
    s_in_valid = 1'b0;
    model_x = 8'h33;
  endtask

  task automatic test_stream();
    logic [7:0] dir [3];
    logic       v;
    logic [7:0] d;
    logic [7:0] exp_x;
    dir[0] = 8'h05; dir[1] = 8'h7F; dir[2] = 8'h80;
    d = 8'h00;
    for (int s = 0; s < 44; s++) begin
      if (s < 3) begin
        v = 1'b1; d = dir[s];
      end else if (s == 3) begin
        v = 1'b0;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        d = 8'($urandom);
      end
      s_in_valid = v;
      s_in_data  = d;
      @(negedge clk);
      exp_x = v ? d : model_x;
      model_x = exp_x;
      tests_run++;
      if ({s_in_ready, cfg_busy, s_set_coeffs, s_axis_fir_tvalid, x_n} !== {1'b1, 1'b0, 1'b0, v, exp_x}) begin
        tests_failed++;
        $display("FAIL stream step %0d: got rdy=%b busy=%b set=%b vld=%b x=%h, want rdy=1 busy=0 set=0 vld=%b x=%h",
                 s, s_in_ready, cfg_busy, s_set_coeffs, s_axis_fir_tvalid, x_n, v, exp_x);
      end
    end
    idle_inputs();
  endtask

  task automatic test_load(input bit rnd);
    cyc_t       e;
    int         val;
    int         a;
    int         lows;
    logic       with_sample;
    logic [7:0] d;
    for (int k = 0; k < N; k++) begin
      val = rnd ? int'($urandom_range(0, 63)) - 32 : k - 10;
      cfg_wr   = 1'b1;
      cfg_addr = ADDR_W'(k);
      cfg_data = val[5:0];
      model_bank[k] = val;
      @(negedge clk);
    end
    if (rnd) begin
      for (int k = 0; k < 8; k++) begin
        a   = int'($urandom_range(0, 31));
        val = int'($urandom_range(0, 63)) - 32;
        cfg_addr = a[ADDR_W-1:0];
        cfg_data = val[5:0];
        if (a < N) model_bank[a] = val;
        @(negedge clk);
      end
    end
    cfg_wr = 1'b0;
    with_sample = rnd;
    d = 8'($urandom);
    exp_q.delete();
    push_load(with_sample, with_sample ? d : model_x);
    push_cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    lows = 0;
    for (int s = 0; s < exp_q.size(); s++) begin
      idle_inputs();
      if (s == 0) begin
        cfg_commit = 1'b1;
        s_in_valid = with_sample;
        s_in_data  = d;
      end
      @(negedge clk);
      if (!s_in_ready) lows++;
      e = exp_q[s];
      tests_run++;
      if ({s_in_ready, cfg_busy, s_set_coeffs, s_axis_fir_tvalid, x_n} !== {e.ready, e.busy, e.set, e.valid, e.x}) begin
        tests_failed++;
        $display("FAIL load(rnd=%0d) step %0d: got rdy=%b busy=%b set=%b vld=%b x=%h, want rdy=%b busy=%b set=%b vld=%b x=%h",
                 rnd, s, s_in_ready, cfg_busy, s_set_coeffs, s_axis_fir_tvalid, x_n,
                 e.ready, e.busy, e.set, e.valid, e.x);
      end
    end
    tests_run++;
    if (lows != N + 2) begin
      tests_failed++;
      $display("FAIL ready_low_cycles: got %0d, want %0d", lows, N + 2);
    end
    idle_inputs();
    model_x = 8'h00;
  endtask

  task automatic test_commit_during_load();
    cyc_t e;
    cfg_wr   = 1'b1;
    cfg_addr = ADDR_W'(3);
    cfg_data = 6'h3B;
    model_bank[3] = -5;
    @(negedge clk);
    exp_q.delete();
    push_load(1'b0, model_x);
    push_cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    push_load(1'b0, 8'h00);
    push_cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int s = 0; s < exp_q.size(); s++) begin
      idle_inputs();
      if (s == 0 || s == 1 || s == 7) cfg_commit = 1'b1;
      if (s == 9) begin
        cfg_wr   = 1'b1;
        cfg_addr = ADDR_W'(3);
        cfg_data = 6'd7;
      end
      @(negedge clk);
      e = exp_q[s];
      tests_run++;
      if ({s_in_ready, cfg_busy, s_set_coeffs, s_axis_fir_tvalid, x_n} !== {e.ready, e.busy, e.set, e.valid, e.x}) begin
        tests_failed++;
        $display("FAIL reload step %0d: got rdy=%b busy=%b set=%b vld=%b x=%h, want rdy=%b busy=%b set=%b vld=%b x=%h",
                 s, s_in_ready, cfg_busy, s_set_coeffs, s_axis_fir_tvalid, x_n,
                 e.ready, e.busy, e.set, e.valid, e.x);
      end
    end
    idle_inputs();
    model_x = 8'h00;
  endtask

  task automatic test_reset_mid_load();
    cyc_t e;
    int   cnt;
    exp_q.delete();
    push_load(1'b0, model_x);
    for (int s = 0; s < 12; s++) begin
      idle_inputs();
      if (s == 0) cfg_commit = 1'b1;
      @(negedge clk);
      e = exp_q[s];
      tests_run++;
      if ({s_in_ready, cfg_busy, s_set_coeffs, s_axis_fir_tvalid, x_n} !== {e.ready, e.busy, e.set, e.valid, e.x}) begin
        tests_failed++;
        $display("FAIL preload step %0d: got set=%b x=%h, want set=%b x=%h",
                 s, s_set_coeffs, x_n, e.set, e.x);
      end
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({s_in_ready, s_set_coeffs, s_axis_fir_tvalid, x_n, cfg_busy} !== {11'b0, BOOTLOAD}) begin
      tests_failed++;
      $display("FAIL async_reset: got rdy=%b set=%b vld=%b x=%h busy=%b, want rdy=0 set=0 vld=0 x=00 busy=%b",
               s_in_ready, s_set_coeffs, s_axis_fir_tvalid, x_n, cfg_busy, BOOTLOAD);
    end
    @(negedge clk);
    reset = 1'b1;
    bank_identity();
    model_x = 8'h00;
    cnt = 0;
    while (!s_in_ready && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    tests_run++;
    if (cnt != BOOT_CYC) begin
      tests_failed++;
      $display("FAIL boot_restart: ready after %0d cycles, want %0d", cnt, BOOT_CYC);
    end
    exp_q.delete();
    push_load(1'b0, 8'h00);
    push_cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int s = 0; s < exp_q.size(); s++) begin
      idle_inputs();
      if (s == 0) cfg_commit = 1'b1;
      @(negedge clk);
      e = exp_q[s];
      tests_run++;
      if ({s_in_ready, cfg_busy, s_set_coeffs, s_axis_fir_tvalid, x_n} !== {e.ready, e.busy, e.set, e.valid, e.x}) begin
        tests_failed++;
        $display("FAIL identity_load step %0d: got rdy=%b busy=%b set=%b vld=%b x=%h, want rdy=%b busy=%b set=%b vld=%b x=%h",
                 s, s_in_ready, cfg_busy, s_set_coeffs, s_axis_fir_tvalid, x_n,
                 e.ready, e.busy, e.set, e.valid, e.x);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_load(1'b0);
    test_stream();
    test_load(1'b1);
    test_commit_during_load();
    test_reset_mid_load();
    test_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
